// File: rtl/snake_body_scan.sv
// ---------------------------------------------------------------------------
// snake_body_scan
//
// Purpose:
//    Keeps a circular history of the last DEPTH snake positions, newest
//    first, and on request scans that history against a key. The compare
//    mode is chosen at run time. The scan reports the age of the first
//    entry whose compare is true.
//
// Ports:
//    clk        clock; all state changes on the rising edge
//    rst_n      asynchronous active-low reset
//    clear      synchronous flush of the history; aborts any running scan
//    push       store push_data as the newest entry
//    push_data  position word to store
//    push_err   one-cycle pulse when a push was dropped during a scan
//    start      scan request, accepted only while not scanning
//    mode       compare mode, sampled with start
//    key        scan key, sampled with start
//    busy       high while the scan is walking the history
//    done       one-cycle pulse when a scan completes
//    hit        SUC_VAL on a match, otherwise the inverse; held between scans
//    hit_idx    age of the first matching entry (0 = newest), 0 on a miss
//    count      number of valid history entries, 0..DEPTH
// ---------------------------------------------------------------------------
module snake_body_scan #(
   parameter int   N       = 8,
   parameter int   DEPTH   = 16,
   parameter logic SUC_VAL = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic [N-1:0]             push_data,
   output logic                     push_err,
   input  logic                     start,
   input  logic [2:0]               mode,
   input  logic [N-1:0]             key,
   output logic                     busy,
   output logic                     done,
   output logic                     hit,
   output logic [$clog2(DEPTH)-1:0] hit_idx,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int IW = $clog2(DEPTH);
   localparam logic [IW:0] FULL = (IW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  mem_q [DEPTH];
   logic [IW-1:0] wp_q, wp_d;
   logic [IW:0]   count_q, count_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [IW-1:0] wpLat_q, wpLat_d;
   logic [IW:0]   cntLat_q, cntLat_d;
   logic [2:0]    mode_q, mode_d;
   logic [N-1:0]  key_q, key_d;
   logic          hit_q, hit_d;
   logic [IW-1:0] hitIdx_q, hitIdx_d;
   logic          pushErr_q, pushErr_d;

   logic          pushOk;
   logic [IW-1:0] rdIdx;
   logic [N-1:0]  entry;
   logic          cmpTrue;

   // A push is only written while no scan is walking the array, so the
   // history cannot shift under the scan. Clear discards any push.
   assign pushOk = push && !clear && (state_q != SCAN);

   // Age i lives at slot (wp - 1 - i); the pointer arithmetic wraps
   // naturally because DEPTH is a power of two.
   assign rdIdx = wpLat_q - IW'(1) - idx_q;
   assign entry = mem_q[rdIdx];

   // Unsigned compare of the current entry against the latched key.
   always_comb begin
      cmpTrue = 1'b1;
      case (mode_q)
         3'd0:    cmpTrue = (entry == key_q);
         3'd1:    cmpTrue = (entry >  key_q);
         3'd2:    cmpTrue = (entry <  key_q);
         3'd3:    cmpTrue = (entry >= key_q);
         3'd4:    cmpTrue = (entry <= key_q);
         default: cmpTrue = 1'b1;
      endcase
   end

   // Write pointer and occupancy. Once the history is full the count
   // stays at DEPTH and the oldest slot is simply overwritten.
   always_comb begin
      wp_d      = wp_q;
      count_d   = count_q;
      pushErr_d = push && !clear && (state_q == SCAN);
      if (clear) begin
         wp_d    = '0;
         count_d = '0;
      end else if (pushOk) begin
         wp_d = wp_q + IW'(1);
         if (count_q != FULL) begin
            count_d = count_q + (IW+1)'(1);
         end
      end
   end

   // Scan controller. A start latches the post-push pointer and count so
   // that a simultaneous push is visible to the scan as age 0. Clear wins
   // over everything but leaves the last result untouched.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      wpLat_d  = wpLat_q;
      cntLat_d = cntLat_q;
      mode_d   = mode_q;
      key_d    = key_q;
      hit_d    = hit_q;
      hitIdx_d = hitIdx_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               key_d    = key;
               mode_d   = mode;
               wpLat_d  = wp_d;
               cntLat_d = count_d;
               idx_d    = '0;
               if (count_d != '0) begin
                  state_d = SCAN;
               end else begin
                  state_d  = DONE;
                  hit_d    = ~SUC_VAL;
                  hitIdx_d = '0;
               end
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         SCAN: begin
            if (cmpTrue) begin
               state_d  = DONE;
               hit_d    = SUC_VAL;
               hitIdx_d = idx_q;
            end else if ({1'b0, idx_q} == cntLat_q - (IW+1)'(1)) begin
               state_d  = DONE;
               hit_d    = ~SUC_VAL;
               hitIdx_d = '0;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      if (clear) begin
         state_d  = IDLE;
         hit_d    = hit_q;
         hitIdx_d = hitIdx_q;
      end
   end

   // Control and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         wp_q      <= '0;
         count_q   <= '0;
         idx_q     <= '0;
         wpLat_q   <= '0;
         cntLat_q  <= '0;
         mode_q    <= '0;
         key_q     <= '0;
         hit_q     <= ~SUC_VAL;
         hitIdx_q  <= '0;
         pushErr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wp_q      <= wp_d;
         count_q   <= count_d;
         idx_q     <= idx_d;
         wpLat_q   <= wpLat_d;
         cntLat_q  <= cntLat_d;
         mode_q    <= mode_d;
         key_q     <= key_d;
         hit_q     <= hit_d;
         hitIdx_q  <= hitIdx_d;
         pushErr_q <= pushErr_d;
      end
   end

   // History storage has no reset; entries beyond count are never read.
   always_ff @(posedge clk) begin
      if (pushOk) begin
         mem_q[wp_q] <= push_data;
      end
   end

   assign busy     = (state_q == SCAN);
   assign done     = (state_q == DONE);
   assign hit      = hit_q;
   assign hit_idx  = hitIdx_q;
   assign count    = count_q;
   assign push_err = pushErr_q;

endmodule

// File: tb/tb_snake_body_scan.sv
// ---------------------------------------------------------------------------
// tb_snake_body_scan
//
// Self-checking bench for snake_body_scan. A transaction-level model keeps
// the history as a queue (newest at the front) and predicts every output on
// every cycle from scan latency arithmetic. Directed scenarios add literal
// expectations, and a second instance with SUC_VAL = 0 checks hit polarity.
// ---------------------------------------------------------------------------
module tb_snake_body_scan;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic       push = 1'b0;
   logic [7:0] pushData = '0;
   logic       start = 1'b0;
   logic [2:0] mode = '0;
   logic [7:0] key = '0;
   logic       pushErr, busy, done, hit;
   logic [3:0] hitIdx;
   logic [4:0] count;

   logic       push2 = 1'b0;
   logic [7:0] pushData2 = '0;
   logic       start2 = 1'b0;
   logic [2:0] mode2 = '0;
   logic [7:0] key2 = '0;
   logic       clear2 = 1'b0;
   logic       pushErr2, busy2, done2, hit2;
   logic [3:0] hitIdx2;
   logic [4:0] count2;

   int assertCount = 0;
   int failCount = 0;
   bit chkEn = 1'b0;

   always #5 clk = ~clk;

   snake_body_scan #(.N(8), .DEPTH(16), .SUC_VAL(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .push(push),
      .push_data(pushData), .push_err(pushErr), .start(start),
      .mode(mode), .key(key), .busy(busy), .done(done), .hit(hit),
      .hit_idx(hitIdx), .count(count)
   );

   snake_body_scan #(.N(8), .DEPTH(16), .SUC_VAL(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .clear(clear2), .push(push2),
      .push_data(pushData2), .push_err(pushErr2), .start(start2),
      .mode(mode2), .key(key2), .busy(busy2), .done(done2), .hit(hit2),
      .hit_idx(hitIdx2), .count(count2)
   );

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit modelMatch(input logic [7:0] e, input logic [7:0] k,
                                     input logic [2:0] m);
      case (m)
         3'd0:    return e == k;
         3'd1:    return e > k;
         3'd2:    return e < k;
         3'd3:    return e >= k;
         3'd4:    return e <= k;
         default: return 1'b1;
      endcase
   endfunction

   // Reference model: history queue plus a countdown of remaining busy
   // cycles. A scan that matches at age a stays busy a+1 cycles, a miss
   // stays busy for the whole history length, an empty history none.
   logic [7:0] hist[$];
   int  busyLeft = 0;
   bit  pendHit = 1'b0;
   int  pendIdx = 0;
   bit  wasBusy;
   bit  expDone = 1'b0, expErr = 1'b0, expHit = 1'b0;
   int  expIdx = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist.delete();
         busyLeft = 0;
         expDone  = 1'b0;
         expErr   = 1'b0;
         expHit   = 1'b0;
         expIdx   = 0;
      end else begin
         wasBusy = (busyLeft > 0);
         expErr  = push && !clear && wasBusy;
         expDone = 1'b0;
         if (clear) begin
            hist.delete();
            busyLeft = 0;
         end else if (wasBusy) begin
            busyLeft--;
            if (busyLeft == 0) begin
               expDone = 1'b1;
               expHit  = pendHit;
               expIdx  = pendIdx;
            end
         end else begin
            if (push) begin
               hist.push_front(pushData);
               if (hist.size() > 16) void'(hist.pop_back());
            end
            if (start) begin
               if (hist.size() == 0) begin
                  expDone = 1'b1;
                  expHit  = 1'b0;
                  expIdx  = 0;
               end else begin
                  pendHit  = 1'b0;
                  pendIdx  = 0;
                  busyLeft = hist.size();
                  for (int a = 0; a < hist.size(); a++) begin
                     if (modelMatch(hist[a], key, mode)) begin
                        pendHit  = 1'b1;
                        pendIdx  = a;
                        busyLeft = a + 1;
                        break;
                     end
                  end
               end
            end
         end
      end
   end

   // Every-cycle comparison of the DUT against the model, just after the edge.
   always @(posedge clk) begin
      #1;
      if (rst_n && chkEn) begin
         checkOutput("mdl_busy", 32'(busy), 32'(busyLeft > 0));
         checkOutput("mdl_done", 32'(done), 32'(expDone));
         checkOutput("mdl_push_err", 32'(pushErr), 32'(expErr));
         checkOutput("mdl_hit", 32'(hit), 32'(expHit));
         checkOutput("mdl_hit_idx", 32'(hitIdx), 32'(expIdx));
         checkOutput("mdl_count", 32'(count), 32'(hist.size()));
      end
   end

   // Advance to the next falling edge and return the main inputs to idle.
   task automatic tick();
      @(negedge clk);
      push  = 1'b0;
      start = 1'b0;
      clear = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] d);
      push     = 1'b1;
      pushData = d;
      tick();
   endtask

   // Issue a scan and measure the cycle of done relative to the start edge.
   task automatic runScan(input logic [2:0] m, input logic [7:0] k,
                          input int expLat, input bit expHitV,
                          input int expIdxV, input string name);
      int lat;
      int busyCycles;
      start = 1'b1;
      mode  = m;
      key   = k;
      tick();
      lat = 1;
      busyCycles = 0;
      while (!done && lat < 40) begin
         if (busy) busyCycles++;
         tick();
         lat++;
      end
      checkOutput({name, "_lat"}, 32'(lat), 32'(expLat));
      checkOutput({name, "_busy"}, 32'(busyCycles), 32'(expLat - 1));
      checkOutput({name, "_hit"}, 32'(hit), 32'(expHitV));
      checkOutput({name, "_idx"}, 32'(hitIdx), 32'(expIdxV));
   endtask

   task automatic runScan0(input logic [7:0] k, input bit expHitV, input string name);
      int lat;
      start2 = 1'b1;
      mode2  = 3'd2;
      key2   = k;
      @(negedge clk);
      start2 = 1'b0;
      lat = 1;
      while (!done2 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checkOutput({name, "_lat"}, 32'(lat), 32'd2);
      checkOutput({name, "_hit"}, 32'(hit2), 32'(expHitV));
   endtask

   initial begin
      int lat;
      bit sawDone;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chkEn = 1'b1;

      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_push_err", 32'(pushErr), 32'd0);
      checkOutput("reset_hit", 32'(hit), 32'd0);
      checkOutput("reset_hit_idx", 32'(hitIdx), 32'd0);
      checkOutput("reset_count", 32'(count), 32'd0);
      checkOutput("reset_hit_suc0", 32'(hit2), 32'd1);

      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      checkOutput("count_three", 32'(count), 32'd3);
      runScan(3'd0, 8'h22, 3, 1'b1, 1, "eq_hit");
      runScan(3'd0, 8'h44, 4, 1'b0, 0, "eq_miss");

      for (int i = 0; i < 20; i++) applyStimulus(8'(i));
      checkOutput("count_full", 32'(count), 32'd16);
      runScan(3'd0, 8'h02, 17, 1'b0, 0, "overwritten");
      runScan(3'd0, 8'h04, 17, 1'b1, 15, "oldest");

      clear = 1'b1;
      tick();
      checkOutput("clear_count", 32'(count), 32'd0);
      runScan(3'd5, 8'h00, 1, 1'b0, 0, "empty");

      applyStimulus(8'h09);
      push     = 1'b1;
      pushData = 8'h07;
      runScan(3'd1, 8'h05, 2, 1'b1, 0, "push_start");
      runScan(3'd4, 8'h08, 2, 1'b1, 0, "b2b_le");
      runScan(3'd3, 8'h09, 3, 1'b1, 1, "b2b_ge");
      runScan(3'd2, 8'h07, 3, 1'b0, 0, "lt_miss");

      for (int i = 0; i < 400; i++) begin
         push     = ($urandom_range(0, 2) == 0);
         pushData = 8'($urandom_range(0, 63));
         start    = ($urandom_range(0, 5) == 0);
         mode     = 3'($urandom_range(0, 7));
         key      = 8'($urandom_range(0, 63));
         clear    = ($urandom_range(0, 60) == 0);
         tick();
      end
      repeat (20) tick();

      clear = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) applyStimulus(8'(i * 3));
      start = 1'b1;
      mode  = 3'd0;
      key   = 8'hEE;
      tick();
      lat = 1;
      tick();
      lat++;
      push     = 1'b1;
      pushData = 8'hAA;
      tick();
      lat++;
      checkOutput("busy_push_err", 32'(pushErr), 32'd1);
      checkOutput("busy_push_count", 32'(count), 32'd16);
      start = 1'b1;
      mode  = 3'd5;
      key   = 8'h00;
      tick();
      lat++;
      checkOutput("push_err_pulse", 32'(pushErr), 32'd0);
      while (!done && lat < 40) begin
         tick();
         lat++;
      end
      checkOutput("mid_start_lat", 32'(lat), 32'd17);
      checkOutput("mid_start_hit", 32'(hit), 32'd0);

      start = 1'b1;
      mode  = 3'd0;
      key   = 8'hEE;
      tick();
      tick();
      clear = 1'b1;
      tick();
      checkOutput("clear_busy", 32'(busy), 32'd0);
      checkOutput("clear_abort_count", 32'(count), 32'd0);
      sawDone = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) sawDone = 1'b1;
         tick();
      end
      checkOutput("clear_no_done", 32'(sawDone), 32'd0);

      push2     = 1'b1;
      pushData2 = 8'h80;
      @(negedge clk);
      push2 = 1'b0;
      runScan0(8'h90, 1'b0, "suc0_match");
      runScan0(8'h10, 1'b1, "suc0_miss");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
